alu_seq: RTL

//   Parametrised successor to the 8-bit board ALU: WIDTH-bit operand registers,
//   a 4-bit opcode, shifts, multi-cycle multiply/divide and status flags.

---
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with shared-bus operand registers, start/busy/done handshake,
// single-cycle logic/arithmetic ops and WIDTH-step shift-add MUL / restoring DIV.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] operand,
    input  logic             load_a,
    input  logic             load_b,
    input  logic [3:0]       opcode,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, op_b;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [CW-1:0]    counter;

    logic [WIDTH-1:0] sc_result, sc_hi;
    logic [4:0]       sc_flags;
    logic             sc_c, sc_v, sc_div0;
    logic [WIDTH:0]   add_ext, inc_ext, sub_ext, shl_ext;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_next, div_quo_next;

    assign busy = (state != IDLE);

    // Single-cycle results; the shifted-out SHL bit lands in bit WIDTH of the extended shift.
    always_comb begin
        sc_result = '0;
        sc_hi     = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        sc_div0   = 1'b0;
        add_ext   = {1'b0, a_reg} + {1'b0, b_reg};
        inc_ext   = {1'b0, a_reg} + (WIDTH+1)'(1);
        sub_ext   = {1'b0, a_reg} - {1'b0, b_reg};
        shl_ext   = {1'b0, a_reg} << b_reg;
        case (opcode)
            4'd0: begin
                sc_result = add_ext[WIDTH-1:0];
                sc_c      = add_ext[WIDTH];
                sc_v      = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                            (add_ext[WIDTH-1] != a_reg[WIDTH-1]);
            end
            4'd1: begin
                sc_result = inc_ext[WIDTH-1:0];
                sc_c      = inc_ext[WIDTH];
                sc_v      = !a_reg[WIDTH-1] && inc_ext[WIDTH-1];
            end
            4'd2: begin
                sc_result = sub_ext[WIDTH-1:0];
                sc_c      = sub_ext[WIDTH];
                sc_v      = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                            (sub_ext[WIDTH-1] != a_reg[WIDTH-1]);
            end
            4'd3: sc_result = a_reg ^ b_reg;
            4'd4: sc_result = a_reg | b_reg;
            4'd5: sc_result = a_reg & b_reg;
            4'd6: begin
                sc_result = shl_ext[WIDTH-1:0];
                sc_c      = shl_ext[WIDTH];
            end
            4'd7: sc_result = a_reg >> b_reg;
            4'd9: begin
                sc_result = '1;
                sc_hi     = a_reg;
                sc_div0   = 1'b1;
            end
            default: ;
        endcase
        sc_flags = {sc_div0, sc_v, sc_c, sc_result[WIDTH-1], (sc_result == '0)};
    end

    // One iteration of each multi-cycle algorithm, applied to the accumulator pair.
    always_comb begin
        mul_sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
        mul_hi_next  = mul_sum[WIDTH:1];
        mul_lo_next  = {mul_sum[0], acc_lo[WIDTH-1:1]};
        div_shift    = {acc_hi, acc_lo[WIDTH-1]};
        div_ge       = (div_shift >= {1'b0, op_b});
        div_diff     = div_shift - {1'b0, op_b};
        div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_next = {acc_lo[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && opcode == 4'd8)
                    state_next = MUL;
                else if (start && opcode == 4'd9 && b_reg != '0)
                    state_next = DIV;
            end
            MUL, DIV: begin
                if (counter == CW'(1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            op_b      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            counter   <= '0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_a) a_reg <= operand;
            if (load_b) b_reg <= operand;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (state_next != IDLE) begin
                            acc_hi  <= '0;
                            acc_lo  <= a_reg;
                            op_b    <= b_reg;
                            counter <= CW'(WIDTH);
                        end else begin
                            result    <= sc_result;
                            result_hi <= sc_hi;
                            flags     <= sc_flags;
                            done      <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_hi  <= mul_hi_next;
                    acc_lo  <= mul_lo_next;
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        result    <= mul_lo_next;
                        result_hi <= mul_hi_next;
                        flags     <= {2'b00, (mul_hi_next != '0),
                                      mul_lo_next[WIDTH-1], (mul_lo_next == '0)};
                        done      <= 1'b1;
                    end
                end
                DIV: begin
                    acc_hi  <= div_rem_next;
                    acc_lo  <= div_quo_next;
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        result    <= div_quo_next;
                        result_hi <= div_rem_next;
                        flags     <= {3'b000, div_quo_next[WIDTH-1], (div_quo_next == '0)};
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
